mux_demux: RTL and testbench



---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_chan_fifo.sv | 85 ++++++++
 rtl/mux_demux.sv | 103 ++++++++++
 tb/tb_mux_demux.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, channel-select enum and decode helper for the
// 1-to-4 demultiplexer (mux_demux) and its per-channel FIFOs.
package demux_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned N_CH       = 4;

    typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_D} ch_sel_e;

    // One-hot decode of a channel select: bit0=A ... bit3=D.
    function automatic logic [N_CH-1:0] ch_onehot(input ch_sel_e ch);
        logic [N_CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: one output channel of the demultiplexer.
// Circular FIFO with a registered head word. The head register is loaded with
// the word that will be at the front after this edge, so a push into an empty
// FIFO appears one cycle later, and the last popped word is held once empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write request and data (ignored when full without a pop)
//   pop             read request (ignored when empty)
//   rdata           registered head word / last popped word when empty
//   full, empty     occupancy flags
module demux_chan_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rdata;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rptr_inc;
    logic [CNT_W-1:0] w_rem;
    logic [CNT_W-1:0] w_count_nxt;

    // Qualified pop/push; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        w_pop       = pop & (r_count != '0);
        w_push      = push & ((r_count != CNT_W'(DEPTH)) | w_pop);
        w_rptr_inc  = r_rptr + PTR_W'(1);
        w_rem       = r_count - CNT_W'(w_pop);
        w_count_nxt = w_rem + CNT_W'(w_push);
    end

    // Storage array; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers, count and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            r_count <= w_count_nxt;
            // Nothing left after the pop: the incoming word becomes the head.
            if (w_push && (w_rem == '0)) begin
                r_rdata <= wdata;
            end else if (w_pop && (w_rem != '0)) begin
                r_rdata <= r_mem[w_rptr_inc];
            end
        end
    end

    assign rdata = r_rdata;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/mux_demux.sv
// mux_demux: 1-to-4 registered demultiplexer. Routes in_data into the FIFO
// selected by sel_i; each channel exposes its head word with a valid/ack
// handshake. in_ready is combinational from sel_i/ack so a full channel can
// accept when its consumer pops in the same cycle.
//
// Optional feature macro: MUX_DEMUX_BROADCAST_EN adds input bcast; a
// broadcast push writes all four FIFOs and needs all four not full (same-cycle
// acks are not credited).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data, sel_i    word and destination (0=A .. 3=D)
//   enb, in_ready     source valid / block can accept
//   A, B, C, D        channel head words
//   vld, ack          per-channel head valid / consumer pop (bit0=A)
//   drop_cnt          saturating count of cycles with enb=1 and in_ready=0
//   bcast             (MUX_DEMUX_BROADCAST_EN only) push to all channels
module mux_demux
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            sel_i,
    input  logic                  enb,
`ifdef MUX_DEMUX_BROADCAST_EN
    input  logic                  bcast,
`endif
    output logic                  in_ready,
    output logic [WIDTH-1:0]      A,
    output logic [WIDTH-1:0]      B,
    output logic [WIDTH-1:0]      C,
    output logic [WIDTH-1:0]      D,
    output logic [N_CH-1:0]       vld,
    input  logic [N_CH-1:0]       ack,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [N_CH-1:0]       w_full;
    logic [N_CH-1:0]       w_empty;
    logic [WIDTH-1:0]      w_rdata [N_CH];
    logic [N_CH-1:0]       w_sel_oh;
    logic [N_CH-1:0]       w_push_vec;
    logic                  w_ready;
    logic                  w_push;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Select decode and accept rule.
    always_comb begin
        w_sel_oh = ch_onehot(ch_sel_e'(sel_i));
`ifdef MUX_DEMUX_BROADCAST_EN
        if (bcast) begin
            w_ready    = ~(|w_full);
            w_push_vec = '1;
        end else begin
            w_ready    = ~w_full[sel_i] | ack[sel_i];
            w_push_vec = w_sel_oh;
        end
`else
        w_ready    = ~w_full[sel_i] | ack[sel_i];
        w_push_vec = w_sel_oh;
`endif
        in_ready = ~rst & w_ready;
        w_push   = enb & in_ready;
    end

    // Four independent channel FIFOs.
    for (genvar g = 0; g < int'(N_CH); g++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push & w_push_vec[g]),
            .pop   (ack[g]),
            .wdata (in_data),
            .rdata (w_rdata[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    // Saturating count of blocked source cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (enb && !in_ready && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign A        = w_rdata[0];
    assign B        = w_rdata[1];
    assign C        = w_rdata[2];
    assign D        = w_rdata[3];
    assign vld      = ~w_empty;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mux_demux.sv
// tb_mux_demux: scoreboard bench for mux_demux. Accepted words are queued per
// channel; heads and popped words are compared against the queues.
`timescale 1ns/1ps
module tb_mux_demux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel_i;
    logic             enb;
    logic             bcast;
    logic             in_ready;
    logic [WIDTH-1:0] A, B, C, D;
    logic [3:0]       vld;
    logic [3:0]       ack;
    logic [15:0]      drop_cnt;

    mux_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .sel_i    (sel_i),
        .enb      (enb),
`ifdef MUX_DEMUX_BROADCAST_EN
        .bcast    (bcast),
`endif
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .vld      (vld),
        .ack      (ack),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [WIDTH-1:0] word_q_t[$];
    word_q_t          q [4];
    logic [WIDTH-1:0] hold [4];
    logic [15:0]      exp_drop;
    int               n_chk;
    int               n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_out(input int i);
        case (i)
            0:       return A;
            1:       return B;
            2:       return C;
            default: return D;
        endcase
    endfunction

    // Compare every channel's vld and head/held word, plus drop_cnt.
    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_vld"}, 32'(vld[i]), 32'(q[i].size() != 0));
            check({tag, "_data"}, 32'(dut_out(i)), (q[i].size() != 0) ? 32'(q[i][0]) : 32'(hold[i]));
        end
        check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    // One clock cycle: drive, check in_ready and popped words, update model, check outputs.
    task automatic cyc(input logic e, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] a, input logic b);
        logic rdy;
        enb = e; sel_i = s; in_data = d; ack = a; bcast = b;
        #1;
`ifdef MUX_DEMUX_BROADCAST_EN
        if (b) rdy = (q[0].size() < DEPTH) && (q[1].size() < DEPTH) &&
                     (q[2].size() < DEPTH) && (q[3].size() < DEPTH);
        else   rdy = (q[s].size() < DEPTH) || a[s];
`else
        rdy = (q[s].size() < DEPTH) || a[s];
`endif
        check("in_ready", 32'(in_ready), 32'(rdy));
        for (int i = 0; i < 4; i++) begin
            if (a[i] && q[i].size() != 0) begin
                check("pop_data", 32'(dut_out(i)), 32'(q[i][0]));
                hold[i] = q[i].pop_front();
            end
        end
        if (e && rdy) begin
`ifdef MUX_DEMUX_BROADCAST_EN
            if (b) for (int i = 0; i < 4; i++) q[i].push_back(d);
            else   q[s].push_back(d);
`else
            q[s].push_back(d);
`endif
        end else if (e && exp_drop != 16'hFFFF) begin
            exp_drop++;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    // One-cycle synchronous reset; model is cleared.
    task automatic do_reset();
        rst = 1'b1; enb = 1'b0; ack = '0; bcast = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            hold[i] = '0;
        end
        exp_drop = '0;
        check("rst_vld", 32'(vld), 32'(0));
        check("rst_A", 32'(A), 32'(0));
        check("rst_drop", 32'(drop_cnt), 32'(0));
        #1;
        check("rst_ready_after", 32'(in_ready), 32'(1));
        check_outputs("rst");
    endtask

    initial begin
        n_chk = 0; n_pass = 0; exp_drop = '0;
        rst = 1'b1; enb = 1'b0; sel_i = '0; in_data = '0; ack = '0; bcast = 1'b0;
        for (int i = 0; i < 4; i++) hold[i] = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Routing to all four channels.
        cyc(1'b1, 2'd0, 8'h11, 4'h0, 1'b0);
        cyc(1'b1, 2'd1, 8'h22, 4'h0, 1'b0);
        cyc(1'b1, 2'd2, 8'h33, 4'h0, 1'b0);
        cyc(1'b1, 2'd3, 8'h44, 4'h0, 1'b0);
        check("route_vld", 32'(vld), 32'hF);
        check("route_D", 32'(D), 32'h44);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

        // Fill channel B and hold a blocked third word for three cycles.
        cyc(1'b1, 2'd1, 8'hA0, 4'h0, 1'b0);
        cyc(1'b1, 2'd1, 8'hA1, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd1, 8'hA2, 4'h0, 1'b0);
        check("bp_B", 32'(B), 32'hA0);
        check("bp_drop", 32'(drop_cnt), 32'd3);
        cyc(1'b0, 2'd1, 8'h00, 4'h2, 1'b0);
        cyc(1'b0, 2'd1, 8'h00, 4'h2, 1'b0);

        // Push on full with same-cycle ack.
        cyc(1'b1, 2'd2, 8'hC0, 4'h0, 1'b0);
        cyc(1'b1, 2'd2, 8'hC1, 4'h0, 1'b0);
        cyc(1'b1, 2'd2, 8'hC2, 4'h4, 1'b0);
        check("pp_C", 32'(C), 32'hC1);
        cyc(1'b0, 2'd2, 8'h00, 4'h4, 1'b0);
        cyc(1'b0, 2'd2, 8'h00, 4'h4, 1'b0);
        check("pp_C_held", 32'(C), 32'hC2);

        // Wrap-around through channel D.
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 2'd3, 8'(k), 4'h0, 1'b0);
            cyc(1'b0, 2'd0, 8'h00, 4'h8, 1'b0);
        end
        check("wrap_D_last", 32'(D), 32'd9);

        // Ack with everything empty, then reset with words stored in A.
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        check("empty_ack_vld", 32'(vld), 32'h0);
        cyc(1'b1, 2'd0, 8'h5E, 4'h0, 1'b0);
        cyc(1'b1, 2'd0, 8'h5F, 4'h0, 1'b0);
        do_reset();

`ifdef MUX_DEMUX_BROADCAST_EN
        // Broadcast fills all four; A then full blocks a further broadcast.
        cyc(1'b1, 2'd2, 8'h5A, 4'h0, 1'b1);
        check("bc_vld", 32'(vld), 32'hF);
        check("bc_C", 32'(C), 32'h5A);
        cyc(1'b1, 2'd0, 8'h5B, 4'h0, 1'b0);
        cyc(1'b1, 2'd1, 8'h77, 4'h1, 1'b1);
        check("bc_drop", 32'(drop_cnt), 32'd1);
        do_reset();
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                4'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
